// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered RV32IM ALU-control decoder. Non-M ops complete in
// one cycle; M ops hold the block busy for a latency chosen by funct3[2].
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              op5,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [2:0]        DATAMEMControl,
  output logic              md_start_o,
  output logic              busy_o
);

  localparam int unsigned LAT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                md_start_q, md_start_d;
  logic                busy_q, busy_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [2:0]          dmem_ctrl_q, dmem_ctrl_d;

  logic                is_m;
  logic [4:0]          dec_ctrl;
  int unsigned         m_lat;
  logic                accept;

  // Combinational decode of ALUOp/funct fields into an operation code.
  always_comb begin
    is_m     = 1'b0;
    dec_ctrl = OP_ADD;
    case (ALUOp)
      2'b01: dec_ctrl = OP_SUB;
      2'b10: begin
        if (op5 && funct7_0) begin
          is_m     = 1'b1;
          dec_ctrl = {2'b10, funct3};
        end else begin
          case (funct3)
            3'b000:  dec_ctrl = (op5 && funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  dec_ctrl = OP_SLL;
            3'b010:  dec_ctrl = OP_SLT;
            3'b011:  dec_ctrl = OP_SLTU;
            3'b100:  dec_ctrl = OP_XOR;
            3'b101:  dec_ctrl = funct7_5 ? OP_SRA : OP_SRL;
            3'b110:  dec_ctrl = OP_OR;
            default: dec_ctrl = OP_AND;
          endcase
        end
      end
      default: dec_ctrl = OP_ADD;
    endcase
  end

  assign m_lat   = funct3[2] ? DIV_CYCLES : MUL_CYCLES;
  assign ready_o = (state_q == IDLE) && !rst;
  assign accept  = valid_i && ready_o;

  // Next-state logic. An M op with latency 1 never enters BUSY, so it
  // completes exactly like a single-cycle op.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    md_start_d  = 1'b0;
    alu_ctrl_d  = alu_ctrl_q;
    dmem_ctrl_d = dmem_ctrl_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        alu_ctrl_d  = CTRL_W'(dec_ctrl);
        dmem_ctrl_d = funct3;
        md_start_d  = is_m;
        if (is_m && (m_lat > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(m_lat - 1);
        end else begin
          valid_d = 1'b1;
        end
      end
    end else begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    busy_d = (state_d == BUSY);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      md_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      alu_ctrl_q  <= '0;
      dmem_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      md_start_q  <= md_start_d;
      busy_q      <= busy_d;
      alu_ctrl_q  <= alu_ctrl_d;
      dmem_ctrl_q <= dmem_ctrl_d;
    end
  end

  assign valid_o        = valid_q;
  assign md_start_o     = md_start_q;
  assign busy_o         = busy_q;
  assign ALUControl     = alu_ctrl_q;
  assign DATAMEMControl = dmem_ctrl_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scenarios plus random stimulus, checked every
// cycle against a cycle-number based reference model.
module tb_alu_ctrl_seq;

  localparam int CTRL_W = 5;
  localparam int MUL_C  = 2;
  localparam int DIV_C  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush_i, valid_i, ready_o;
  logic [1:0]        ALUOp;
  logic [2:0]        funct3;
  logic              funct7_5, funct7_0, op5;
  logic              valid_o, md_start_o, busy_o;
  logic [CTRL_W-1:0] ALUControl;
  logic [2:0]        DATAMEMControl;

  alu_ctrl_seq #(.CTRL_W(CTRL_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .op5(op5), .valid_o(valid_o), .ALUControl(ALUControl),
    .DATAMEMControl(DATAMEMControl), .md_start_o(md_start_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: events tracked as absolute cycle numbers.
  int         cyc        = 0;
  int         ready_from = 0;
  int         valid_at   = -1;
  int         start_at   = -1;
  logic [4:0] m_alu      = '0;
  logic [2:0] m_dmem     = '0;

  function automatic logic [4:0] ref_ctrl(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic f75, input logic f70, input logic o5);
    int base [8] = '{0, 6, 5, 9, 4, 7, 3, 2};
    if (aop == 2'b01) return 5'd1;
    if (aop != 2'b10) return 5'd0;
    if (o5 && f70) return 5'(16 + int'(f3));
    if (f3 == 3'd0 && o5 && f75) return 5'd1;
    if (f3 == 3'd5 && f75) return 5'd8;
    return 5'(base[f3]);
  endfunction

  task automatic step(input logic r, input logic fl, input logic v, input logic [1:0] aop,
                      input logic [2:0] f3, input logic f75, input logic f70, input logic o5);
    int         lat;
    logic [4:0] c;
    rst = r; flush_i = fl; valid_i = v; ALUOp = aop; funct3 = f3;
    funct7_5 = f75; funct7_0 = f70; op5 = o5;
    if (r) begin
      ready_from = cyc + 1; valid_at = -1; start_at = -1; m_alu = '0; m_dmem = '0;
    end else if (fl) begin
      ready_from = cyc + 1; valid_at = -1; start_at = -1;
    end else if (v && cyc >= ready_from) begin
      c      = ref_ctrl(aop, f3, f75, f70, o5);
      m_alu  = c;
      m_dmem = f3;
      lat    = c[4] ? (f3[2] ? DIV_C : MUL_C) : 1;
      valid_at   = cyc + lat;
      start_at   = c[4] ? cyc + 1 : -1;
      ready_from = cyc + lat;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("ready_o",        32'(ready_o),       32'((cyc >= ready_from) && !rst));
    check("busy_o",         32'(busy_o),        32'(cyc < ready_from));
    check("valid_o",        32'(valid_o),       32'(cyc == valid_at));
    check("md_start_o",     32'(md_start_o),    32'(cyc == start_at));
    check("ALUControl",     32'(ALUControl),    32'(m_alu));
    check("DATAMEMControl", 32'(DATAMEMControl), 32'(m_dmem));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic       r, fl, v, f75, f70, o5;
    logic [1:0] aop;
    logic [2:0] f3;
    logic [3:0] f3b;

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ALUOp = '0; funct3 = '0;
    funct7_5 = 1'b0; funct7_0 = 1'b0; op5 = 1'b0;
    @(negedge clk);

    // Reset held two cycles with valid_i high.
    step(1'b1, 1'b0, 1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 1'b1);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_alu",   32'(ALUControl), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    idle();
    check("post_rst_ready", 32'(ready_o), 32'd1);

    // R-type sweep, back-to-back accepts.
    for (int i = 0; i < 16; i++) begin
      f3b = 4'(i);
      step(1'b0, 1'b0, 1'b1, 2'b10, f3b[2:0], f3b[3], 1'b0, 1'b1);
      check("rtype_valid", 32'(valid_o), 32'd1);
      if (i == 8)  check("rtype_sub", 32'(ALUControl), 32'b00001);
      if (i == 13) check("rtype_sra", 32'(ALUControl), 32'b01000);
    end

    // I-type addi with funct7_5 set; load with ALUOp 00.
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0);
    check("addi", 32'(ALUControl), 32'b00000);
    step(1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0);
    check("ld_alu",  32'(ALUControl), 32'b00000);
    check("ld_dmem", 32'(DATAMEMControl), 32'b010);

    // DIV: busy 31 cycles, later requests ignored.
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 1'b1);
    check("div_start", 32'(md_start_o), 32'd1);
    check("div_alu",   32'(ALUControl), 32'b10100);
    for (int i = 2; i <= DIV_C; i++) begin
      step(1'b0, 1'b0, (i < DIV_C) ? 1'b1 : 1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1);
      check("div_valid", 32'(valid_o), 32'(i == DIV_C));
      check("div_ready", 32'(ready_o), 32'(i == DIV_C));
    end
    check("div_alu_end", 32'(ALUControl), 32'b10100);

    // MUL then add back to back.
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 1'b1);
    check("mul_start", 32'(md_start_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    check("mul_valid", 32'(valid_o), 32'd1);
    check("mul_alu",   32'(ALUControl), 32'b10000);
    step(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_alu",   32'(ALUControl), 32'b00000);

    // Flush at T+5 of a DIV.
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'b110, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    step(1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
    check("flush_busy",  32'(busy_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_keep",  32'(ALUControl), 32'b10110);
    for (int i = 0; i < 35; i++) idle();

    // Reset mid-BUSY.
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle();
    step(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rstb_busy", 32'(busy_o), 32'd0);
    check("rstb_alu",  32'(ALUControl), 32'd0);
    idle();
    check("rstb_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 35; i++) idle();

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 9) < 7);
      aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      f3  = 3'($urandom_range(0, 7));
      f75 = 1'($urandom_range(0, 1));
      f70 = ($urandom_range(0, 3) == 0);
      o5  = 1'($urandom_range(0, 1));
      step(r, fl, v, aop, f3, f75, f70, o5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
